// File: rtl/fb_video_pkg.sv
// fb_video_pkg: shared 640x480@60 timing constants, coordinate/pixel types and control bundle
package fb_video_pkg;
  localparam int CW = 10;
  localparam int PW = 8;
  typedef logic [CW-1:0] coord_t;
  typedef logic [PW-1:0] pix_t;
  localparam coord_t H_ACTIVE = 10'd640;
  localparam coord_t H_FP     = 10'd16;
  localparam coord_t H_SYNC   = 10'd96;
  localparam coord_t H_BP     = 10'd48;
  localparam coord_t V_ACTIVE = 10'd480;
  localparam coord_t V_FP     = 10'd10;
  localparam coord_t V_SYNC   = 10'd2;
  localparam coord_t V_BP     = 10'd33;
  localparam coord_t H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam coord_t V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t FB_W     = H_ACTIVE;
  localparam coord_t FB_H     = V_ACTIVE;
  localparam coord_t BAR_W    = FB_W / 10'd8;
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vctl_t;
  function automatic logic in_win(coord_t c, coord_t lo, coord_t len);
    return c >= lo && c < lo + len;
  endfunction
endpackage

// File: rtl/fb_scanout_timing.sv
// video_timing_gen: h/v counters and stage-0 de/hsync/vsync/frame-start flags (active-high)
// Ports: clk, reset (async, active-high), enable_i (0 holds counters and blanks flags),
//   h_cnt_o/v_cnt_o current position, ctl_o stage-0 control flags.
module video_timing_gen import fb_video_pkg::*; #(
  parameter coord_t H_ACTIVE = fb_video_pkg::H_ACTIVE,
  parameter coord_t H_FP     = fb_video_pkg::H_FP,
  parameter coord_t H_SYNC   = fb_video_pkg::H_SYNC,
  parameter coord_t H_BP     = fb_video_pkg::H_BP,
  parameter coord_t V_ACTIVE = fb_video_pkg::V_ACTIVE,
  parameter coord_t V_FP     = fb_video_pkg::V_FP,
  parameter coord_t V_SYNC   = fb_video_pkg::V_SYNC,
  parameter coord_t V_BP     = fb_video_pkg::V_BP
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enable_i,
  output coord_t h_cnt_o,
  output coord_t v_cnt_o,
  output vctl_t  ctl_o
);
  localparam coord_t H_LAST = H_ACTIVE + H_FP + H_SYNC + H_BP - 10'd1;
  localparam coord_t V_LAST = V_ACTIVE + V_FP + V_SYNC + V_BP - 10'd1;
  coord_t h_q, h_d, v_q, v_d;
  logic   h_wrap;
  always_comb begin
    h_wrap   = h_q == H_LAST;
    h_d      = enable_i ? (h_wrap ? '0 : h_q + 10'd1) : h_q;
    v_d      = enable_i && h_wrap ? (v_q == V_LAST ? '0 : v_q + 10'd1) : v_q;
    ctl_o.de = enable_i && h_q < H_ACTIVE && v_q < V_ACTIVE;
    ctl_o.hs = enable_i && in_win(h_q, H_ACTIVE + H_FP, H_SYNC);
    ctl_o.vs = enable_i && in_win(v_q, V_ACTIVE + V_FP, V_SYNC);
    ctl_o.fs = enable_i && h_q == '0 && v_q == '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  assign h_cnt_o = h_q;
  assign v_cnt_o = v_q;
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: frame-buffer scanout, 640x480@60 timing with read data realigned to syncs (2-cycle latency)
// Ports: clk, reset (async, active-high), enable (0 freezes timing, blanks outputs),
//   rdaddress_x/rdaddress_y -> buffer read port, read_data <- buffer (valid 1 cycle after address),
//   hsync/vsync (level per SYNC_POL), de, pixel (0 when de=0), frame_start -> TMDS encoder.
// Build option SCANOUT_TEST_PATTERN_EN adds input test_pattern selecting 8 vertical grey bars.
module fb_scanout import fb_video_pkg::*; #(
  parameter coord_t H_ACTIVE = fb_video_pkg::H_ACTIVE,
  parameter coord_t H_FP     = fb_video_pkg::H_FP,
  parameter coord_t H_SYNC   = fb_video_pkg::H_SYNC,
  parameter coord_t H_BP     = fb_video_pkg::H_BP,
  parameter coord_t V_ACTIVE = fb_video_pkg::V_ACTIVE,
  parameter coord_t V_FP     = fb_video_pkg::V_FP,
  parameter coord_t V_SYNC   = fb_video_pkg::V_SYNC,
  parameter coord_t V_BP     = fb_video_pkg::V_BP,
  parameter logic   SYNC_POL = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic   test_pattern,
`endif
  output coord_t rdaddress_x,
  output coord_t rdaddress_y,
  input  pix_t   read_data,
  output logic   hsync,
  output logic   vsync,
  output logic   de,
  output pix_t   pixel,
  output logic   frame_start
);
  coord_t h_cnt, v_cnt;
  vctl_t  ctl0, ctl1_q;
  logic   de_q, hs_q, vs_q, fs_q;
  pix_t   pix_d, pix_q;
  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk     (clk),
    .reset   (reset),
    .enable_i(enable),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .ctl_o   (ctl0)
  );
  assign rdaddress_x = h_cnt < H_ACTIVE ? h_cnt : '0;
  assign rdaddress_y = v_cnt < V_ACTIVE ? v_cnt : '0;
`ifdef SCANOUT_TEST_PATTERN_EN
  coord_t h1_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) h1_q <= '0;
    else h1_q <= h_cnt;
  // column of the pixel now in stage 1 picks one of eight bars, 0x20 apart
  always_comb pix_d = !ctl1_q.de ? '0 : test_pattern ? pix_t'(h1_q / BAR_W) << 5 : read_data;
`else
  always_comb pix_d = ctl1_q.de ? read_data : '0;
`endif
  // stage 1 waits out the buffer read; stage 2 joins the returned data with the delayed flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctl1_q <= '0;
      de_q   <= 1'b0;
      fs_q   <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      pix_q  <= '0;
    end else begin
      ctl1_q <= ctl0;
      de_q   <= ctl1_q.de;
      fs_q   <= ctl1_q.fs;
      hs_q   <= ctl1_q.hs ? SYNC_POL : ~SYNC_POL;
      vs_q   <= ctl1_q.vs ? SYNC_POL : ~SYNC_POL;
      pix_q  <= pix_d;
    end
  assign de          = de_q;
  assign frame_start = fs_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign pixel       = pix_q;
endmodule
